aes256_key_expander: RTL and testbench

Upstream key-schedule stage for the AES-256 LUT pipeline. It reads the 256-bit cipher key as eight 32-bit words from a source BRAM port and expands it per FIPS-197 into 60 round-key words (15 round keys, 1920 bits). The words are written one per clock into the key BRAM that the AES core later walks with its 8-bit byte address. When `doneOut` rises, the key memory holds w[0..59] at byte addresses 0x00..0xEC, and the core may be started.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_subword.sv | 16 +
 rtl/aes256_key_expander.sv | 142 ++++++++++++++
 tb/tb_aes256_key_expander.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box and Rcon tables, key-schedule sizes and the
// key-expander state encoding.
package aes_pkg;

  localparam int NK             = 8;
  localparam int NW             = 60;
  localparam int NR             = 14;
  localparam int KEY_WORD_BYTES = 4;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Index 0 is never used: the first round constant belongs to w[8].
  localparam logic [0:7][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } keyState_e;

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] wordIn,
  output logic [31:0] wordOut
);

  always_comb begin
    wordOut = '0;
    for (int b = 0; b < 4; b++) begin
      wordOut[8*b +: 8] = SBOX[wordIn[8*b +: 8]];
    end
  end

endmodule

// File: rtl/aes256_key_expander.sv
// AES-256 key schedule: reads the 8-word cipher key from a source BRAM and
// writes the 60 expanded words, one per clock, into the key BRAM.
module aes256_key_expander
  import aes_pkg::*;
#(
  parameter int NK = 8,
  parameter int NW = 60
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        startIn,
  input  logic [31:0] keyWordIn,
  output logic [2:0]  keyRdAddrOut,
  output logic [7:0]  keyWrAddrOut,
  output logic [31:0] keyWrDataOut,
  output logic [3:0]  keyWeOut,
  output logic        busyOut,
  output logic        doneOut
);

  keyState_e            state;
  keyState_e            stateNext;
  logic [3:0]           loadCnt;
  logic [5:0]           wordIdx;
  logic                 lastWr;
  // window[0] holds w[i-1], window[NK-1] holds w[i-8]
  logic [NK-1:0][31:0]  window;
  logic [31:0]          prevWord;
  logic [31:0]          subIn;
  logic [31:0]          subOut;
  logic [31:0]          temp;
  logic [31:0]          newWord;
  logic                 loadWrite;
  logic                 expandWrite;

  assign loadWrite   = (state == LOAD) && (loadCnt >= 4'd2);
  assign expandWrite = (state == EXPAND) && !lastWr;

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: if (startIn) stateNext = LOAD;
      LOAD:       if (loadCnt == 4'(NK + 1)) stateNext = EXPAND;
      EXPAND:     if (lastWr) stateNext = DONE;
      default:    stateNext = IDLE;
    endcase
  end

  assign prevWord = window[0];
  assign subIn    = (wordIdx[2:0] == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

  aes_subword uSubWord (
    .wordIn  (subIn),
    .wordOut (subOut)
  );

  always_comb begin
    temp = prevWord;
    if (wordIdx[2:0] == 3'd0) begin
      temp = subOut ^ {RCON[wordIdx[5:3]], 24'h0};
    end else if (wordIdx[2:0] == 3'd4) begin
      temp = subOut;
    end
    newWord = window[NK-1] ^ temp;
  end

  // Word window: data path only, no reset
  always_ff @(posedge clkIn) begin
    if (loadWrite) begin
      window <= {window[NK-2:0], keyWordIn};
    end else if (expandWrite) begin
      window <= {window[NK-2:0], newWord};
    end
  end

  // Control and registered outputs
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      keyRdAddrOut <= '0;
      keyWrAddrOut <= '0;
      keyWrDataOut <= '0;
      keyWeOut     <= '0;
      busyOut      <= 1'b0;
      doneOut      <= 1'b0;
      loadCnt      <= '0;
      wordIdx      <= '0;
      lastWr       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (startIn) begin
            doneOut <= 1'b0;
            loadCnt <= '0;
            wordIdx <= '0;
            lastWr  <= 1'b0;
          end
        end
        LOAD: begin
          busyOut <= 1'b1;
          loadCnt <= loadCnt + 4'd1;
          if (loadCnt < 4'(NK)) begin
            keyRdAddrOut <= loadCnt[2:0];
          end
          // Source BRAM returns word j two edges after its address edge
          if (loadWrite) begin
            keyWrDataOut <= keyWordIn;
            keyWrAddrOut <= 8'(wordIdx) * 8'(KEY_WORD_BYTES);
            keyWeOut     <= 4'b1111;
            wordIdx      <= wordIdx + 6'd1;
          end
        end
        EXPAND: begin
          if (lastWr) begin
            keyWeOut <= '0;
            busyOut  <= 1'b0;
            doneOut  <= 1'b1;
          end else begin
            keyWrDataOut <= newWord;
            keyWrAddrOut <= 8'(wordIdx) * 8'(KEY_WORD_BYTES);
            keyWeOut     <= 4'b1111;
            // Index saturates on the last word; the flag closes the run
            if (wordIdx == 6'(NW - 1)) begin
              lastWr <= 1'b1;
            end else begin
              wordIdx <= wordIdx + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_expander.sv
// Bench for aes256_key_expander: a source-BRAM model feeds keys, a GF(2^8)
// derived key schedule predicts every write, and timing is checked per cycle.
module tb_aes256_key_expander;

  logic        clkIn   = 1'b0;
  logic        resetIn = 1'b0;
  logic        startIn = 1'b0;
  logic [31:0] keyWordIn;
  logic [2:0]  keyRdAddrOut;
  logic [7:0]  keyWrAddrOut;
  logic [31:0] keyWrDataOut;
  logic [3:0]  keyWeOut;
  logic        busyOut;
  logic        doneOut;

  int total = 0;
  int bad   = 0;

  logic [31:0] keyMem [8];
  logic [7:0]  sboxT  [256];
  logic [31:0] expW   [60];

  aes256_key_expander #(.NK(8), .NW(60)) dut (
    .clkIn        (clkIn),
    .resetIn      (resetIn),
    .startIn      (startIn),
    .keyWordIn    (keyWordIn),
    .keyRdAddrOut (keyRdAddrOut),
    .keyWrAddrOut (keyWrAddrOut),
    .keyWrDataOut (keyWrDataOut),
    .keyWeOut     (keyWeOut),
    .busyOut      (busyOut),
    .doneOut      (doneOut)
  );

  always #5 clkIn = ~clkIn;

  // Source BRAM: one-cycle registered read
  always @(posedge clkIn) keyWordIn <= keyMem[keyRdAddrOut];

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [7:0] r = a;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  function automatic logic [7:0] sboxOf(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subW(input logic [31:0] w);
    return {sboxT[w[31:24]], sboxT[w[23:16]], sboxT[w[15:8]], sboxT[w[7:0]]};
  endfunction

  task automatic expandModel();
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) expW[i] = keyMem[i];
    for (int i = 8; i < 60; i++) begin
      t = expW[i-1];
      if (i % 8 == 0) begin
        t  = subW({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subW(t);
      end
      expW[i] = expW[i-8] ^ t;
    end
  endtask

  task automatic randomKey();
    for (int i = 0; i < 8; i++) keyMem[i] = $urandom;
  endtask

  task automatic checkResetOuts(input string tag);
    checkEq(tag, {keyRdAddrOut, keyWrAddrOut, keyWrDataOut, keyWeOut, busyOut, doneOut}, 64'h0);
  endtask

  // One full run; optional second start pulse, held start, or reset at a cycle
  task automatic runOne(input bit pulse20, input bit holdStart, input int resetAt,
                        input bit chkW8, input logic [31:0] w8Want,
                        input bit chkW59, input logic [31:0] w59Want);
    logic        expBusy;
    logic        expDone;
    logic [3:0]  expWe;
    expandModel();
    @(negedge clkIn);
    startIn = 1'b1;
    @(negedge clkIn);
    if (!holdStart) startIn = 1'b0;
    checkEq("cycle0 busy/done", {busyOut, doneOut}, 2'b00);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clkIn);
      if (holdStart && k == 3) startIn = 1'b0;
      if (pulse20 && k == 20) startIn = 1'b1;
      if (pulse20 && k == 21) startIn = 1'b0;
      if (k == resetAt) begin
        resetIn = 1'b0;
        #1;
        checkResetOuts("async reset outs");
        repeat (2) begin
          @(negedge clkIn);
          checkResetOuts("held reset outs");
        end
        resetIn = 1'b1;
        return;
      end
      expBusy = (k >= 1 && k <= 62);
      expDone = (k >= 63);
      expWe   = (k >= 3 && k <= 62) ? 4'b1111 : 4'b0000;
      checkEq($sformatf("ctl c%0d", k), {busyOut, doneOut, keyWeOut}, {expBusy, expDone, expWe});
      if (k <= 8) checkEq($sformatf("rdAddr c%0d", k), keyRdAddrOut, 64'(k - 1));
      if (k >= 3 && k <= 62) begin
        checkEq($sformatf("wr c%0d", k), {keyWrAddrOut, keyWrDataOut},
                {8'(4 * (k - 3)), expW[k-3]});
      end
      if (chkW8 && k == 11) checkEq("w8 vector", {keyWrAddrOut, keyWrDataOut}, {8'h20, w8Want});
      if (chkW59 && k == 62) checkEq("w59 vector", {keyWrAddrOut, keyWrDataOut}, {8'hec, w59Want});
    end
  endtask

  initial begin
    for (int v = 0; v < 256; v++) sboxT[v] = sboxOf(8'(v));
    for (int i = 0; i < 8; i++) keyMem[i] = '0;

    repeat (2) @(negedge clkIn);
    startIn = 1'b1;
    @(negedge clkIn);
    checkResetOuts("reset state");
    startIn = 1'b0;
    resetIn = 1'b1;
    @(negedge clkIn);
    checkResetOuts("idle after reset");

    keyMem = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
               32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    runOne(1'b0, 1'b0, -1, 1'b1, 32'h9ba35411, 1'b1, 32'h706c631e);

    for (int i = 0; i < 8; i++) keyMem[i] = '0;
    runOne(1'b0, 1'b0, -1, 1'b1, 32'h62636363, 1'b0, 32'h0);

    randomKey();
    runOne(1'b1, 1'b0, -1, 1'b0, 32'h0, 1'b0, 32'h0);

    randomKey();
    runOne(1'b0, 1'b0, 30, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clkIn);
    checkEq("done after reset", {busyOut, doneOut}, 2'b00);

    randomKey();
    runOne(1'b0, 1'b1, -1, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int n = 0; n < 50; n++) begin
      randomKey();
      runOne(1'b0, 1'b0, -1, 1'b0, 32'h0, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
